// File: rtl/raster_pkg.sv
// ============================================================================
//  raster_pkg
//  Shared types and constants for the raster pixel collection path.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package raster_pkg;

    localparam int GRID    = 8;
    localparam int COORD_W = 3;

    // Row index, shared with the rasterizer and the frame-buffer writer
    typedef logic [COORD_W-1:0] row_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One-hot column mask for a pixel x coordinate
    function automatic logic [GRID-1:0] col_mask(input logic [COORD_W-1:0] x);
        return GRID'(1) << x;
    endfunction

    // Next row in drain order (down = walk from the bottom row upwards)
    function automatic row_idx_t step_row(input row_idx_t r, input logic down);
        return down ? r - row_idx_t'(1) : r + row_idx_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_bitmap.sv
// ============================================================================
//  raster_bitmap
//  8x8 flop bitmap: set port returning the old bit, synchronous clear that
//  merges with a same-cycle set, and a registered row read port.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_bitmap
    import raster_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               set_en,
    input  logic [COORD_W-1:0] set_x,
    input  logic [COORD_W-1:0] set_y,
    output logic               old_bit,
    input  logic               rd_en,
    input  logic [COORD_W-1:0] rd_y,
    output logic [GRID-1:0]    rd_data
);

    logic [GRID-1:0][GRID-1:0] bits;
    logic [GRID-1:0][GRID-1:0] bits_nxt;

    // Old bit is the pre-clear value; the caller decides what a clear means
    assign old_bit = bits[set_y][set_x];

    // Clear first, then set, so a pixel in the clearing cycle survives
    always_comb begin
        bits_nxt = clr ? '0 : bits;
        if (set_en) begin
            bits_nxt[set_y] = bits_nxt[set_y] | col_mask(set_x);
        end
    end

    // Bitmap storage and row read; reading the next-state value lets the
    // first drained row include a pixel written on the very same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits    <= '0;
            rd_data <= '0;
        end else begin
            bits <= bits_nxt;
            if (rd_en) begin
                rd_data <= bits_nxt[rd_y];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/raster_collector.sv
// ============================================================================
//  raster_collector
//  Captures one triangle's pixel stream into an 8x8 bitmap, counts distinct
//  pixels, flags duplicates, and drains the bitmap row by row over
//  valid/ready once the rasterizer drops busy.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_collector
    import raster_pkg::*;
#(
    parameter bit BOTTOM_UP = 1'b0,
    parameter int CNT_W     = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy_in,
    input  logic               po,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [COORD_W-1:0] rd_row,
    output logic [GRID-1:0]    rd_data,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic               dup_err,
    output logic               overrun,
    output logic               done
);

    localparam row_idx_t         FIRST_ROW = BOTTOM_UP ? row_idx_t'(GRID-1) : row_idx_t'(0);
    localparam row_idx_t         LAST_ROW  = BOTTOM_UP ? row_idx_t'(0) : row_idx_t'(GRID-1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(GRID*GRID);

    state_t             state;
    logic               busy_d;
    logic               rise;
    logic               fall;
    logic               arm;
    logic               set_en;
    logic               old_bit;
    logic               fresh;
    logic               cap_end;
    logic               handshake;
    logic               rd_en;
    logic [COORD_W-1:0] rd_y;

    assign rise      = busy_in & ~busy_d;
    assign fall      = ~busy_in & busy_d;
    assign arm       = (state == ST_IDLE) && rise;
    assign set_en    = po && (arm || (state == ST_CAPTURE));
    // A bit that is being cleared this cycle counts as not yet set
    assign fresh     = arm || !old_bit;
    assign cap_end   = (state == ST_CAPTURE) && fall;
    assign handshake = rd_valid && rd_ready;
    assign rd_en     = cap_end || (handshake && (rd_row != LAST_ROW));
    assign rd_y      = cap_end ? FIRST_ROW : step_row(rd_row, BOTTOM_UP);

    raster_bitmap u_bitmap (
        .clk     (clk),
        .reset   (reset),
        .clr     (arm),
        .set_en  (set_en),
        .set_x   (xi),
        .set_y   (yi),
        .old_bit (old_bit),
        .rd_en   (rd_en),
        .rd_y    (rd_y),
        .rd_data (rd_data)
    );

    // Frame control: capture window, pixel statistics and row drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy_d   <= 1'b0;
            pix_cnt  <= '0;
            dup_err  <= 1'b0;
            rd_valid <= 1'b0;
            rd_row   <= '0;
            overrun  <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy_d  <= busy_in;
            overrun <= rise && (state != ST_IDLE);
            done    <= 1'b0;

            if (arm) begin
                pix_cnt <= set_en ? CNT_W'(1) : '0;
                dup_err <= 1'b0;
            end else if (set_en) begin
                if (fresh) begin
                    if (pix_cnt < CNT_MAX) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                end else begin
                    dup_err <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (fall) begin
                        state    <= ST_DRAIN;
                        rd_valid <= 1'b1;
                        rd_row   <= FIRST_ROW;
                    end
                end
                ST_DRAIN: begin
                    if (handshake) begin
                        if (rd_row == LAST_ROW) begin
                            state    <= ST_DONE;
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rd_row <= step_row(rd_row, BOTTOM_UP);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/raster_collector.md
Name: raster_collector

Overview:
- Downstream consumer of the triangle rasterizer's point stream (busy, po, xo, yo).
- Captures every emitted pixel of one triangle into an 8x8 bitmap and counts the pixels.
- Flags duplicate emissions.
- After the rasterizer drops busy, drains the bitmap row by row over a valid/ready interface to the frame-buffer writer.

Parameters:
- BOTTOM_UP, 0, drain order: 0 = rows 0..7, 1 = rows 7..0.
- CNT_W, 7, width of the pixel counter; must hold 64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- busy_in  input  1  rasterizer busy; high for the duration of one triangle
- po  input  1  pixel-valid strobe from the rasterizer
- xi  input  3  pixel x (column), valid when po=1
- yi  input  3  pixel y (row), valid when po=1
- rd_valid  output  1  drained row available
- rd_ready  input  1  downstream accepts the row when rd_valid && rd_ready
- rd_row  output  3  row index of rd_data
- rd_data  output  8  bitmap row; bit k = pixel (x=k, y=rd_row)
- pix_cnt  output  CNT_W  distinct pixels captured in the current/last frame
- dup_err  output  1  sticky: a pixel was emitted twice in the current frame
- overrun  output  1  one-cycle pulse: busy_in rose while not in IDLE
- done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bitmap=0; pix_cnt=0; dup_err=0.
  - rd_valid=0, rd_row=0, rd_data=0, overrun=0, done=0.
- busy_in rise detection: busy_d register; rise = busy_in & ~busy_d; fall = ~busy_in & busy_d.
- IDLE:
  - On rise: clear bitmap, pix_cnt and dup_err; go to CAPTURE next cycle.
  - A po asserted in the rise cycle is captured, i.e. the clear and the set merge so the pixel survives.
  - po outside CAPTURE and the rise cycle is ignored.
- CAPTURE:
  - Each cycle with po=1: if bitmap[yi][xi]==0, set it and pix_cnt+=1; else set dup_err (pix_cnt unchanged).
  - On fall: go to DRAIN. A po in the same cycle as fall is still captured.
  - Row pointer loads 0, or 7 if BOTTOM_UP=1.
- DRAIN:
  - rd_valid=1; rd_row=pointer; rd_data=bitmap[pointer], registered so it is stable while rd_valid && !rd_ready.
  - On handshake: advance the pointer (+1, or -1 if BOTTOM_UP).
  - Handshake on the last row (7, or 0 if BOTTOM_UP): rd_valid=0 next cycle; go to DONE.
  - Minimum drain = 8 cycles with rd_ready tied high.
- DONE: done=1 for exactly one cycle; go to IDLE. pix_cnt and dup_err hold until the next rise.
- rise while in CAPTURE (a glitch) is impossible by definition; rise while in DRAIN or DONE:
  - overrun pulses; the frame is not captured; the drain continues unaffected.
  - The block re-arms only on a rise seen in IDLE.
- Empty triangle (busy high, no po): all 8 rows drain as 0x00; pix_cnt=0.
- pix_cnt saturates at 64, which is unreachable with a correct rasterizer.
- Asynchronous reset mid-drain: immediate return to IDLE, rd_valid=0, no done pulse.

Decomposition:
- Shared package raster_pkg:
  - GRID=8, COORD_W=3.
  - State encoding IDLE/CAPTURE/DRAIN/DONE (2 bits).
  - A row-index type, shared with the rasterizer and the frame-buffer writer.
- One natural sub-module: raster_bitmap, an 8x8 flop array.
  - Set port (x, y, en) returns the old bit.
  - Synchronous clear.
  - Registered row read port.
- The FSM, counter and handshake stay in raster_collector.

Test Plan:
- Triangle (1,1),(5,1),(1,5) (pixels with x+y<=6, x,y>=1), rd_ready=1 → pix_cnt=15; rows 0..7 = 00,3E,1E,0E,06,02,00,00; done 8 cycles after fall; dup_err=0.
- Same triangle with BOTTOM_UP=1 → rd_row sequence 7..0, data 00,00,02,06,0E,1E,3E,00.
- rd_ready toggling 1,0,0,1,... during drain → rd_row/rd_data hold while stalled; each row is delivered exactly once; done only after row 7.
- Pixel (3,2) emitted twice inside one busy window → pix_cnt=1, dup_err=1, row2=0x08.
- busy_in rises during DRAIN → overrun pulses for 1 cycle; drained data unchanged; the next rise in IDLE captures normally with pix_cnt restarted from 0.
- reset pulled low after 3 rows drained → rd_valid=0 and pix_cnt=0 immediately; no done pulse; the next frame works correctly.
